// File: rtl/decode_hazard_unit.sv
// Forwarding-select and load-use stall controller for the decode stage.
// Tracks the EX and MEM destination tags and derives per-operand mux selects.

module decode_hazard_operand #(
  parameter logic [4:0] ZR = 5'd31
) (
  input  logic       uses,
  input  logic [4:0] a,
  input  logic       ex_src,
  input  logic [4:0] ex_aw,
  input  logic       ex_mr,
  input  logic       mem_src,
  input  logic [4:0] mem_aw,
  output logic [1:0] fwd,
  output logic       hit
);
  logic ex_hit, mem_hit;

  assign ex_hit  = uses && (a != ZR) && ex_src  && (ex_aw  == a);
  assign mem_hit = uses && (a != ZR) && mem_src && (mem_aw == a);

  // A load in EX has no result yet: fall through to MEM (the stall covers it).
  always_comb begin
    fwd = 2'b00;
    if (ex_hit && !ex_mr) fwd = 2'b01;
    else if (mem_hit)     fwd = 2'b10;
  end

  assign hit = ex_hit & ex_mr;
endmodule

module decode_hazard_unit #(
  parameter int         CNT_W = 16,
  parameter logic [4:0] ZR    = 5'd31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             DecValid,
  input  logic [4:0]       DecAa,
  input  logic [4:0]       DecAb,
  input  logic [4:0]       DecAw,
  input  logic             DecUsesA,
  input  logic             DecUsesB,
  input  logic             DecRegWrite,
  input  logic             DecMemRead,
  input  logic             Flush,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             Stall,
  output logic             ExTagValid,
  output logic [CNT_W-1:0] StallCount
);
  localparam int NUM_LANES = 2;

  typedef struct packed {
    logic       v;
    logic [4:0] aw;
    logic       rw;
    logic       mr;
  } ex_tag_t;

  typedef struct packed {
    logic       v;
    logic [4:0] aw;
    logic       rw;
  } mem_tag_t;

  ex_tag_t  ex_tag;
  mem_tag_t mem_tag;
  logic     ex_src, mem_src;

  logic [NUM_LANES-1:0][4:0] opnd_a;
  logic [NUM_LANES-1:0]      opnd_uses;
  logic [NUM_LANES-1:0][1:0] opnd_fwd;
  logic [NUM_LANES-1:0]      opnd_hit;

  assign ex_src  = ex_tag.v  & ex_tag.rw  & (ex_tag.aw  != ZR);
  assign mem_src = mem_tag.v & mem_tag.rw & (mem_tag.aw != ZR);

  assign opnd_a    = {DecAb, DecAa};
  assign opnd_uses = {DecUsesB, DecUsesA};

  genvar l;
  generate
    for (l = 0; l < NUM_LANES; l++) begin : g_lane
      decode_hazard_operand #(.ZR(ZR)) u_opnd (
        .uses    (opnd_uses[l]),
        .a       (opnd_a[l]),
        .ex_src  (ex_src),
        .ex_aw   (ex_tag.aw),
        .ex_mr   (ex_tag.mr),
        .mem_src (mem_src),
        .mem_aw  (mem_tag.aw),
        .fwd     (opnd_fwd[l]),
        .hit     (opnd_hit[l])
      );
    end
  endgenerate

  assign ForwardA   = opnd_fwd[0];
  assign ForwardB   = opnd_fwd[1];
  assign Stall      = DecValid & ~Flush & (|opnd_hit);
  assign ExTagValid = ex_tag.v & ex_tag.rw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_tag     <= '0;
      mem_tag    <= '0;
      StallCount <= '0;
    end else begin
      mem_tag <= '{v: ex_tag.v, aw: ex_tag.aw, rw: ex_tag.rw};
      if (Stall || Flush || !DecValid) ex_tag <= '0;
      else ex_tag <= '{v: 1'b1, aw: DecAw, rw: DecRegWrite, mr: DecMemRead};
      // Saturate rather than wrap so long runs still read as "many".
      if (Stall && (StallCount != {CNT_W{1'b1}})) StallCount <= StallCount + 1'b1;
    end
  end
endmodule

// File: tb/tb_decode_hazard_unit.sv
// Directed bench for decode_hazard_unit: forwarding, load-use, XZR, flush,
// reset and counter saturation (CNT_W = 4).

module tb_decode_hazard_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic       DecValid, DecUsesA, DecUsesB, DecRegWrite, DecMemRead, Flush;
  logic [4:0] DecAa, DecAb, DecAw;
  logic [1:0] ForwardA, ForwardB;
  logic       Stall, ExTagValid;
  logic [3:0] StallCount;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_hazard_unit #(.CNT_W(4), .ZR(5'd31)) dut (
    .clk(clk), .reset(reset),
    .DecValid(DecValid), .DecAa(DecAa), .DecAb(DecAb), .DecAw(DecAw),
    .DecUsesA(DecUsesA), .DecUsesB(DecUsesB), .DecRegWrite(DecRegWrite),
    .DecMemRead(DecMemRead), .Flush(Flush),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .Stall(Stall),
    .ExTagValid(ExTagValid), .StallCount(StallCount)
  );

  task automatic drive(input logic v, input logic [4:0] aa, input logic ua,
                       input logic [4:0] ab, input logic ub,
                       input logic [4:0] aw, input logic rw, input logic mr,
                       input logic fl);
    DecValid = v; DecAa = aa; DecUsesA = ua; DecAb = ab; DecUsesB = ub;
    DecAw = aw; DecRegWrite = rw; DecMemRead = mr; Flush = fl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    tick();
    total++; if (ForwardA !== 2'b00 || ForwardB !== 2'b00) begin bad++; $display("FAIL reset_fwd got %b/%b want 00/00", ForwardA, ForwardB); end
    total++; if (Stall !== 1'b0 || ExTagValid !== 1'b0) begin bad++; $display("FAIL reset_ctl got stall=%b etv=%b want 0/0", Stall, ExTagValid); end
    total++; if (StallCount !== 4'd0) begin bad++; $display("FAIL reset_cnt got %0d want 0", StallCount); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);   // ADD X1
    tick();
    total++; if (ExTagValid !== 1'b1) begin bad++; $display("FAIL b2b_etv got %b want 1", ExTagValid); end
    drive(1'b1, 5'd1, 1'b1, 5'd9, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);   // SUB reads X1
    total++; if (ForwardA !== 2'b01 || Stall !== 1'b0) begin bad++; $display("FAIL b2b_ex got fa=%b st=%b want 01/0", ForwardA, Stall); end
    tick();
    drive(1'b1, 5'd9, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);   // reads X1 on B
    total++; if (ForwardB !== 2'b10 || ForwardA !== 2'b00) begin bad++; $display("FAIL b2b_mem got fb=%b fa=%b want 10/00", ForwardB, ForwardA); end
    tick();
    drive(1'b1, 5'd9, 1'b1, 5'd1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    total++; if (ForwardB !== 2'b00) begin bad++; $display("FAIL b2b_rf got %b want 00", ForwardB); end
    idle(); tick(); tick();
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);   // LDUR X2
    tick();
    drive(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);   // ADD reads X2
    total++; if (Stall !== 1'b1 || ForwardA === 2'b11) begin bad++; $display("FAIL lu_stall got st=%b fa=%b want 1/not11", Stall, ForwardA); end
    total++; if (StallCount !== 4'd0) begin bad++; $display("FAIL lu_cnt0 got %0d want 0", StallCount); end
    tick();
    total++; if (Stall !== 1'b0 || ForwardA !== 2'b10) begin bad++; $display("FAIL lu_after got st=%b fa=%b want 0/10", Stall, ForwardA); end
    total++; if (StallCount !== 4'd1) begin bad++; $display("FAIL lu_cnt1 got %0d want 1", StallCount); end
    idle(); tick(); tick();
  endtask

  task automatic test_priority();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
    total++; if (ForwardA !== 2'b01 || ForwardB !== 2'b01) begin bad++; $display("FAIL prio got %b/%b want 01/01", ForwardA, ForwardB); end
    idle(); tick(); tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd31, 1'b1, 1'b1, 1'b0);  // load to XZR
    tick();
    drive(1'b1, 5'd31, 1'b1, 5'd31, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0);
    total++; if (ForwardA !== 2'b00 || ForwardB !== 2'b00 || Stall !== 1'b0) begin bad++; $display("FAIL xzr got %b/%b st=%b want 00/00/0", ForwardA, ForwardB, Stall); end
    tick();
    total++; if (ForwardA !== 2'b00 || Stall !== 1'b0) begin bad++; $display("FAIL xzr_mem got %b st=%b want 00/0", ForwardA, Stall); end
    idle(); tick(); tick();
  endtask

  task automatic test_unused();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);   // LDUR X4
    tick();
    drive(1'b1, 5'd4, 1'b0, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);   // B, no reads
    total++; if (Stall !== 1'b0 || ForwardA !== 2'b00) begin bad++; $display("FAIL unused got st=%b fa=%b want 0/00", Stall, ForwardA); end
    idle(); tick(); tick();
    drive(1'b1, 5'd0, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);   // STUR, Aw=5
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0);
    total++; if (ForwardA !== 2'b00 || ForwardB !== 2'b00 || ExTagValid !== 1'b0) begin bad++; $display("FAIL nowrite got %b/%b etv=%b want 00/00/0", ForwardA, ForwardB, ExTagValid); end
    idle(); tick(); tick();
  endtask

  task automatic test_flush();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1);   // hit + Flush
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL flush_stall got %b want 0", Stall); end
    tick();
    total++; if (ExTagValid !== 1'b0 || StallCount !== 4'd1) begin bad++; $display("FAIL flush_tag got etv=%b cnt=%0d want 0/1", ExTagValid, StallCount); end
    idle(); tick(); tick();
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd2, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    total++; if (Stall !== 1'b1) begin bad++; $display("FAIL rst_pre got %b want 1", Stall); end
    reset = 1'b0;
    #1;
    total++; if (Stall !== 1'b0 || ForwardA !== 2'b00 || ForwardB !== 2'b00 || ExTagValid !== 1'b0) begin bad++; $display("FAIL rst_mid got st=%b fa=%b fb=%b etv=%b want 0", Stall, ForwardA, ForwardB, ExTagValid); end
    total++; if (StallCount !== 4'd0) begin bad++; $display("FAIL rst_cnt got %0d want 0", StallCount); end
    #1 reset = 1'b1;
    tick();
    total++; if (ExTagValid !== 1'b1 || StallCount !== 4'd0) begin bad++; $display("FAIL rst_after got etv=%b cnt=%0d want 1/0", ExTagValid, StallCount); end
    idle(); tick(); tick();
  endtask

  task automatic test_saturation();
    int exp_cnt;
    // LDUR X2 reading X2: alternates load-in-EX (stall) and bubble (issue).
    drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i <= 41; i++) begin
      exp_cnt = (i / 2 > 15) ? 15 : i / 2;
      total++; if (Stall !== ((i % 2) == 1)) begin bad++; $display("FAIL sat_stall[%0d] got %b want %b", i, Stall, (i % 2) == 1); end
      total++; if (StallCount !== exp_cnt[3:0]) begin bad++; $display("FAIL sat_cnt[%0d] got %0d want %0d", i, StallCount, exp_cnt); end
      tick();
    end
    total++; if (StallCount !== 4'd15) begin bad++; $display("FAIL sat_final got %0d want 15", StallCount); end
    idle(); tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_priority();
    test_unused();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
